// File: rtl/lcd_char_feeder.sv
// Streams a 32-character, two-line buffer to an LCD controller as command/data items.
// Optional periodic self-refresh is enabled with `define LCD_FEED_AUTO_REFRESH_EN.
module lcd_char_feeder #(
   parameter int REFRESH_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_en,
   input  logic [4:0] wr_addr,
   input  logic [7:0] wr_data,
   input  logic       update,
   output logic       out_valid,
   output logic       out_rs,
   output logic [7:0] out_data,
   input  logic       out_ready,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {IDLE, CMD_L1, DATA_L1, CMD_L2, DATA_L2, FIN} state_t;

   state_t     r_state;
   logic       r_pending;
   logic [3:0] r_col;
   logic [7:0] r_buf [0:31];

   logic       w_xfer;
   logic       w_req;
   logic       w_tick;
   logic [3:0] w_col_nxt;

   assign w_xfer    = out_valid & out_ready;
   assign w_col_nxt = r_col + 4'd1;
   assign w_req     = update | w_tick;

`ifdef LCD_FEED_AUTO_REFRESH_EN
   localparam logic [31:0] LP_REFRESH_LAST = 32'(REFRESH_CYCLES - 1);

   logic [31:0] r_refresh_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_refresh_cnt <= '0;
      end else if (r_refresh_cnt == LP_REFRESH_LAST) begin
         r_refresh_cnt <= '0;
      end else begin
         r_refresh_cnt <= r_refresh_cnt + 32'd1;
      end
   end

   assign w_tick = (r_refresh_cnt == LP_REFRESH_LAST);
`else
   assign w_tick = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) begin
            r_buf[i] <= 8'h20;
         end
      end else if (wr_en) begin
         r_buf[wr_addr] <= wr_data;
      end
   end

   // Items are loaded into out_data on the transfer that retires the previous one,
   // so a same-cycle write to the addressed entry is not seen by that item.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_pending <= 1'b0;
         r_col     <= 4'd0;
         out_valid <= 1'b0;
         out_rs    <= 1'b0;
         out_data  <= 8'h00;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         if (w_req && (r_state != IDLE)) begin
            r_pending <= 1'b1;
         end
         case (r_state)
            IDLE: begin
               if (w_req || r_pending) begin
                  r_state   <= CMD_L1;
                  r_pending <= 1'b0;
                  out_valid <= 1'b1;
                  out_rs    <= 1'b0;
                  out_data  <= 8'h80;
                  busy      <= 1'b1;
               end
            end
            CMD_L1: begin
               if (w_xfer) begin
                  r_state  <= DATA_L1;
                  out_rs   <= 1'b1;
                  out_data <= r_buf[{1'b0, r_col}];
               end
            end
            DATA_L1: begin
               if (w_xfer) begin
                  r_col <= w_col_nxt;
                  if (r_col == 4'd15) begin
                     r_state  <= CMD_L2;
                     out_rs   <= 1'b0;
                     out_data <= 8'hC0;
                  end else begin
                     out_data <= r_buf[{1'b0, w_col_nxt}];
                  end
               end
            end
            CMD_L2: begin
               if (w_xfer) begin
                  r_state  <= DATA_L2;
                  out_rs   <= 1'b1;
                  out_data <= r_buf[{1'b1, r_col}];
               end
            end
            DATA_L2: begin
               if (w_xfer) begin
                  r_col <= w_col_nxt;
                  if (r_col == 4'd15) begin
                     r_state   <= FIN;
                     out_valid <= 1'b0;
                     done      <= 1'b1;
                  end else begin
                     out_data <= r_buf[{1'b1, w_col_nxt}];
                  end
               end
            end
            FIN: begin
               r_state <= IDLE;
               done    <= 1'b0;
               busy    <= 1'b0;
            end
            default: begin
               r_state   <= IDLE;
               out_valid <= 1'b0;
               done      <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_char_feeder.sv
// Directed bench for lcd_char_feeder: stream contents, back-pressure, pending updates, reset abort.
module tb_lcd_char_feeder;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       wr_en = 1'b0;
   logic [4:0] wr_addr = '0;
   logic [7:0] wr_data = '0;
   logic       update = 1'b0;
   logic       out_ready = 1'b1;
   logic       out_valid, out_rs, busy, done;
   logic [7:0] out_data;

   always #5 clk = ~clk;

   lcd_char_feeder #(.REFRESH_CYCLES(100)) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .update(update), .out_valid(out_valid), .out_rs(out_rs), .out_data(out_data),
      .out_ready(out_ready), .busy(busy), .done(done)
   );

   typedef struct { logic rs; logic [7:0] data; } item_t;
   typedef struct { logic [4:0] addr; logic [7:0] data; } wr_vec_t;

   int         n_tests = 0;
   int         n_fail = 0;
   logic [7:0] model_buf [32];
   item_t      exp_q [34];
   wr_vec_t    wr_tab [32];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   function automatic void build_exp();
      exp_q[0] = '{1'b0, 8'h80};
      for (int i = 0; i < 16; i++) exp_q[1 + i] = '{1'b1, model_buf[i]};
      exp_q[17] = '{1'b0, 8'hC0};
      for (int i = 0; i < 16; i++) exp_q[18 + i] = '{1'b1, model_buf[16 + i]};
   endfunction

   // Runs one stream from its start; optional stall on item stall_k and mid-stream update pulses.
   task automatic run_stream(input bit do_update, input int stall_k, input bit pulses,
                             output int done_cnt);
      int k = 0;
      int busy_cnt = 0;
      int stall = 0;
      done_cnt = 0;
      build_exp();
      if (do_update) begin
         @(negedge clk); update = 1'b1;
         @(negedge clk); update = 1'b0;
         check("latency_valid", {31'd0, out_valid}, 32'd1);
      end else begin
         for (int i = 0; i < 5 && !out_valid; i++) @(negedge clk);
         check("pending_start", {31'd0, out_valid}, 32'd1);
      end
      for (int cyc = 0; cyc < 300; cyc++) begin
         if (!busy) break;
         if (k == stall_k && stall < 5) begin
            out_ready = 1'b0; wr_en = 1'b1; wr_addr = 5'd2; wr_data = 8'h7A;
         end else begin
            out_ready = 1'b1; wr_en = 1'b0;
         end
         update = pulses && (cyc == 5 || cyc == 10 || cyc == 20);
         busy_cnt++;
         if (done) done_cnt++;
         if (out_valid && !out_ready) begin
            check("stall_hold", {24'd0, out_data}, {24'd0, exp_q[k].data});
            stall++;
         end
         if (out_valid && out_ready) begin
            if (k < 34) begin
               check($sformatf("item%0d_rs", k), {31'd0, out_rs}, {31'd0, exp_q[k].rs});
               check($sformatf("item%0d_data", k), {24'd0, out_data}, {24'd0, exp_q[k].data});
            end else begin
               check("extra_item", k, 33);
            end
            k++;
         end
         @(negedge clk);
      end
      update = 1'b0; wr_en = 1'b0; out_ready = 1'b1;
      check("stream_ended", {31'd0, busy}, 32'd0);
      check("item_count", k, 34);
      check("busy_cycles", busy_cnt, (stall_k >= 0) ? 40 : 35);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, d1;
      int cnt;
      for (int i = 0; i < 16; i++) wr_tab[i] = '{5'(i), 8'(8'h41 + i)};
      for (int i = 0; i < 16; i++) wr_tab[16 + i] = '{5'(16 + i), 8'(8'h61 + i)};
      for (int i = 0; i < 32; i++) model_buf[i] = 8'h20;

      #2 reset = 1'b1;
      @(negedge clk);
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_rs", {31'd0, out_rs}, 32'd0);
      check("rst_data", {24'd0, out_data}, 32'd0);
      @(negedge clk); reset = 1'b0;

`ifdef LCD_FEED_AUTO_REFRESH_EN
      begin
         int starts [$];
         logic prev = 1'b0;
         for (int c = 0; c < 450; c++) begin
            @(negedge clk);
            if (out_valid && !prev) starts.push_back(c);
            prev = out_valid;
         end
         check("refresh_starts", (starts.size() >= 4) ? 1 : 0, 1);
         for (int i = 1; i < starts.size(); i++)
            check("refresh_interval", starts[i] - starts[i - 1], 100);
      end
`else
      cnt = 0;
      for (int c = 0; c < 1000; c++) begin
         @(negedge clk);
         if (out_valid || busy) cnt++;
      end
      check("no_auto_stream", cnt, 0);

      run_stream(1'b1, -1, 1'b0, d0);
      check("done_once_blank", d0, 1);

      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         wr_en = 1'b1; wr_addr = wr_tab[i].addr; wr_data = wr_tab[i].data;
         model_buf[wr_tab[i].addr] = wr_tab[i].data;
      end
      @(negedge clk); wr_en = 1'b0;
      run_stream(1'b1, -1, 1'b0, d0);
      check("done_once_pattern", d0, 1);

      run_stream(1'b1, 3, 1'b0, d0);
      model_buf[2] = 8'h7A;
      run_stream(1'b1, -1, 1'b0, d0);

      run_stream(1'b1, -1, 1'b1, d0);
      run_stream(1'b0, -1, 1'b0, d1);
      check("done_total_pending", d0 + d1, 2);
      cnt = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (out_valid || busy) cnt++;
      end
      check("no_third_stream", cnt, 0);

      @(negedge clk); update = 1'b1;
      @(negedge clk); update = 1'b0;
      repeat (25) @(negedge clk);
      check("pre_abort_busy", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      #1;
      check("abort_valid", {31'd0, out_valid}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      @(negedge clk); reset = 1'b0;
      for (int i = 0; i < 32; i++) model_buf[i] = 8'h20;
      cnt = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (out_valid || busy || done) cnt++;
      end
      check("no_resume", cnt, 0);
      run_stream(1'b1, -1, 1'b0, d0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/lcd_char_feeder.md
LCD_CHAR_FEEDER -- requirements
Module: lcd_char_feeder

Interface
REQ-001 SHALL have parameter REFRESH_CYCLES, default 50000, meaning the clk cycles between automatic refresh requests (used only when LCD_FEED_AUTO_REFRESH_EN is defined).
REQ-002 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port wr_en  input  1  write strobe for the character buffer.
REQ-005 SHALL have port wr_addr  input  5  buffer index; 0-15 is line 1, 16-31 is line 2.
REQ-006 SHALL have port wr_data  input  8  character code to store.
REQ-007 SHALL have port update  input  1  single-cycle request to stream the whole buffer to the LCD controller.
REQ-008 SHALL have port out_valid  output  1  an item is presented downstream.
REQ-009 SHALL have port out_rs  output  1  item type: 0 is a command byte, 1 is a character byte.
REQ-010 SHALL have port out_data  output  8  item byte.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the item.
REQ-012 SHALL have port busy  output  1  high while a stream is in progress.
REQ-013 SHALL have port done  output  1  one-cycle pulse when a stream completes.

Function
REQ-014 SHALL hold a 32x8 register buffer; when wr_en=1, wr_data is written to wr_addr on the clock edge, in any state.
REQ-015 SHALL implement the FSM states IDLE, CMD_L1, DATA_L1, CMD_L2, DATA_L2 and FIN.
REQ-016 SHALL move IDLE->CMD_L1 on update=1 (or a pending request), with out_valid=1 on the following cycle, so latency from update to out_valid is 1 clk.
REQ-017 SHALL present 0x80 (rs=0) in CMD_L1, characters 0-15 (rs=1) in DATA_L1, 0xC0 (rs=0) in CMD_L2, and characters 16-31 (rs=1) in DATA_L2, for exactly 34 transfers per stream.
REQ-018 SHALL count a transfer only on a cycle with out_valid=1 and out_ready=1, and SHALL advance the item or state only on such a transfer.
REQ-019 SHALL keep out_valid, out_rs and out_data stable while out_valid=1 and out_ready=0.
REQ-020 SHALL register out_data from the buffer when an item is loaded; a write to that address in the same cycle yields the old value (read-before-write), and later writes do not alter an item already presented.
REQ-021 SHALL use a 4-bit column index that wraps from 15 to 0 on moving DATA_L1->CMD_L2 and DATA_L2->FIN.
REQ-022 SHALL pass through FIN for one cycle with out_valid=0 and done=1, then return to IDLE.
REQ-023 SHALL assert busy in every state except IDLE.
REQ-024 SHALL, on update=1 while busy=1, set a single pending flag, and further updates SHALL NOT queue additional streams.
REQ-025 SHALL, on update=1 in FIN, also set the pending flag.
REQ-026 SHALL leave IDLE for CMD_L1 on the cycle after FIN when pending=1, and SHALL clear pending on that cycle.
REQ-027 SHALL accept out_ready=1 while out_valid=0 with no effect.

Reset
REQ-028 SHALL, on reset=1, immediately and asynchronously force state=IDLE, out_valid=0, out_rs=0, out_data=0x00, busy=0, done=0 and pending=0, and clear the column index and refresh counter.
REQ-029 SHALL, on reset=1, initialise every buffer entry to 0x20 (space).
REQ-030 SHALL abandon any stream in progress on reset, and SHALL NOT resume that stream after reset is released.

Configuration
REQ-031 SHALL, with LCD_FEED_AUTO_REFRESH_EN defined, run a free-running counter that raises an internal update every REFRESH_CYCLES clocks, with pending rules identical to external update.
REQ-032 SHALL, without LCD_FEED_AUTO_REFRESH_EN, contain no refresh counter, so streams start only from the update port.

Verification
REQ-033 Reset, then update with out_ready held at 1 -> out_valid on the next cycle; the sequence is 0x80, 16x0x20, 0xC0, 16x0x20; done pulses once; busy is high for exactly 35 cycles.
REQ-034 Write 0x41..0x50 to addresses 0-15 and 0x61..0x70 to addresses 16-31, then update -> stream 0x80, 0x41..0x50, 0xC0, 0x61..0x70, with rs=0,1x16,0,1x16.
REQ-035 Hold out_ready=0 for 5 cycles on item 3 while writing 0x7A to address 2 -> out_data holds the original value with no duplicate or skipped item; next update shows 0x7A.
REQ-036 Pulse update 3 times mid-stream -> exactly one further stream starts after the FIN cycle, and done pulses twice in total.
REQ-037 Assert reset during DATA_L2 -> out_valid=0 and busy=0 in the same cycle; after release no output until the next update, and the buffer reads all 0x20.
REQ-038 With LCD_FEED_AUTO_REFRESH_EN defined and REFRESH_CYCLES=100 -> streams start every 100 cycles with no external update; without the macro, no stream starts in 1000 cycles.
